// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Covers the write request and FIFO entry layouts plus the register-0 test.
package wb_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int FIFO_DEPTH = 4;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic    live;
    wb_req_t req;
  } wb_entry_t;

  function automatic logic is_real_reg(input logic [ADDR_W-1:0] addr);
    return addr != REG_ZERO;
  endfunction
endpackage

// File: rtl/wb_if.sv
// Bundles the request, register-file and decode-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface wb_if;
  import wb_pkg::*;

  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic              we3;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd3;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [DATA_W-1:0] rd1_raw;
  logic [DATA_W-1:0] rd2_raw;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              hazard1;
  logic              hazard2;

  modport slave (
    input  p_we, p_addr, p_data, s_valid, s_addr, s_data,
           a1, a2, rd1_raw, rd2_raw,
    output s_ready, we3, a3, wd3, rd1, rd2, hazard1, hazard2
  );

  modport master (
    output p_we, p_addr, p_data, s_valid, s_addr, s_data,
           a1, a2, rd1_raw, rd2_raw,
    input  s_ready, we3, a3, wd3, rd1, rd2, hazard1, hazard2
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular queue of pending secondary writes with kill-by-address and
// two address-match outputs used for decode hazard detection.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  wb_req_t           push_req_i,
  input  logic              pop_i,
  output wb_entry_t         head_o,
  output logic              full_o,
  output logic              empty_o,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] kill_addr_i,
  input  logic [ADDR_W-1:0] match1_addr_i,
  input  logic [ADDR_W-1:0] match2_addr_i,
  output logic              match1_o,
  output logic              match2_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         entries_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;

  assign count_d = count_q + CW'(push_i) - CW'(pop_i);
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = entries_q[rd_ptr_q];

  // Popped slots are cleared so only queued, un-killed entries stay live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && entries_q[i].req.addr == kill_addr_i)
          entries_q[i].live <= 1'b0;
      end
      if (pop_i) begin
        entries_q[rd_ptr_q].live <= 1'b0;
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_i) begin
        entries_q[wr_ptr_q] <= '{live: 1'b1, req: push_req_i};
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    match1_o = 1'b0;
    match2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].live && entries_q[i].req.addr == match1_addr_i) match1_o = 1'b1;
      if (entries_q[i].live && entries_q[i].req.addr == match2_addr_i) match2_o = 1'b1;
    end
    if (!is_real_reg(match1_addr_i)) match1_o = 1'b0;
    if (!is_real_reg(match2_addr_i)) match2_o = 1'b0;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Drives the register-file write port from a 1-cycle primary source and a
// queued secondary source; also forwards the staged write to decode reads.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = wb_pkg::FIFO_DEPTH
) (
  input logic clk,
  input logic rst_n,
  wb_if.slave bus
);
  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;

  logic      p_take, s_push, pop, full, empty;
  wb_entry_t head;

  assign p_take = bus.p_we && is_real_reg(bus.p_addr);
  assign s_push = bus.s_valid && !full && is_real_reg(bus.s_addr);
  assign pop    = !p_take && !empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (s_push),
    .push_req_i   ('{addr: bus.s_addr, data: bus.s_data}),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .kill_i       (p_take),
    .kill_addr_i  (bus.p_addr),
    .match1_addr_i(bus.a1),
    .match2_addr_i(bus.a2),
    .match1_o     (bus.hazard1),
    .match2_o     (bus.hazard2)
  );

  // Primary always wins; a killed head pops as a bubble with address/data held.
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (p_take) begin
      we3_d = 1'b1;
      a3_d  = bus.p_addr;
      wd3_d = bus.p_data;
    end else if (pop) begin
      we3_d = head.live;
      if (head.live) begin
        a3_d  = head.req.addr;
        wd3_d = head.req.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
    end
  end

  assign bus.s_ready = !full;
  assign bus.we3     = we3_q;
  assign bus.a3      = a3_q;
  assign bus.wd3     = wd3_q;

  // The register file only commits at the end of the we3 cycle.
  assign bus.rd1 = (we3_q && a3_q == bus.a1 && is_real_reg(bus.a1)) ? wd3_q : bus.rd1_raw;
  assign bus.rd2 = (we3_q && a3_q == bus.a2 && is_real_reg(bus.a2)) ? wd3_q : bus.rd2_raw;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a behavioural 32x32 register file.
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [31:0] regs [32];

  wb_if bus ();

  writeback_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.we3 && bus.a3 != 5'd0) regs[bus.a3] <= bus.wd3;

  assign bus.rd1_raw = regs[bus.a1];
  assign bus.rd2_raw = regs[bus.a2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.p_we = 1'b0; bus.p_addr = '0; bus.p_data = '0;
    bus.s_valid = 1'b0; bus.s_addr = '0; bus.s_data = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    idle();
    bus.a1 = '0; bus.a2 = '0;
    #12;
    chk("rst_we3", bus.we3, 0);
    chk("rst_a3", bus.a3, 0);
    chk("rst_wd3", bus.wd3, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_haz1", bus.hazard1, 0);
    chk("rst_haz2", bus.hazard2, 0);
    rst_n = 1'b1;
    tick();

    // Primary only, with forwarding
    bus.p_we = 1'b1; bus.p_addr = 5'd5; bus.p_data = 32'hDEADBEEF; bus.a1 = 5'd5;
    tick();
    bus.p_we = 1'b0;
    chk("prim_we3", bus.we3, 1);
    chk("prim_a3", bus.a3, 5);
    chk("prim_wd3", bus.wd3, 32'hDEADBEEF);
    chk("prim_fwd_rd1", bus.rd1, 32'hDEADBEEF);
    tick();
    chk("prim_idle_we3", bus.we3, 0);
    chk("prim_reg5", regs[5], 32'hDEADBEEF);

    // Fill the FIFO with primary busy on r1
    bus.p_we = 1'b1; bus.p_addr = 5'd1; bus.p_data = 32'h100;
    for (int k = 0; k < 4; k++) begin
      bus.s_valid = 1'b1; bus.s_addr = 5'(10 + k); bus.s_data = 32'(k + 1);
      tick();
    end
    chk("fill_s_ready_full", bus.s_ready, 0);
    bus.s_addr = 5'd14; bus.s_data = 32'd5; bus.a1 = 5'd14; bus.a2 = 5'd10;
    tick();
    chk("fill_still_full", bus.s_ready, 0);
    chk("fill_haz1_rejected", bus.hazard1, 0);
    chk("fill_haz2_queued", bus.hazard2, 1);
    bus.p_we = 1'b0;
    tick();
    bus.s_valid = 1'b0;
    chk("drain0_we3", bus.we3, 1);
    chk("drain0_a3", bus.a3, 10);
    chk("drain0_wd3", bus.wd3, 1);
    chk("drain0_s_ready", bus.s_ready, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("drain_we3", bus.we3, 1);
      chk("drain_a3", bus.a3, 32'(10 + k));
      chk("drain_wd3", bus.wd3, 32'(k + 1));
    end
    tick();
    chk("drain_done_we3", bus.we3, 0);
    chk("drain_haz2_clear", bus.hazard2, 0);

    // WAW kill of a queued r7
    bus.p_we = 1'b1; bus.p_addr = 5'd1; bus.p_data = 32'h200;
    bus.s_valid = 1'b1; bus.s_addr = 5'd7; bus.s_data = 32'h11; bus.a1 = 5'd7; bus.a2 = 5'd0;
    tick();
    bus.s_valid = 1'b0;
    chk("waw_haz1_before", bus.hazard1, 1);
    bus.p_addr = 5'd7; bus.p_data = 32'h22;
    tick();
    bus.p_we = 1'b0;
    chk("waw_haz1_after", bus.hazard1, 0);
    chk("waw_we3", bus.we3, 1);
    chk("waw_wd3", bus.wd3, 32'h22);
    chk("waw_fwd_rd1", bus.rd1, 32'h22);
    tick();
    chk("waw_bubble_we3", bus.we3, 0);
    chk("waw_bubble_a3_hold", bus.a3, 7);
    chk("waw_bubble_wd3_hold", bus.wd3, 32'h22);
    chk("waw_reg7", regs[7], 32'h22);
    tick();
    chk("waw_reg7_final", regs[7], 32'h22);

    // Same-cycle primary and secondary to r3
    bus.p_we = 1'b1; bus.p_addr = 5'd3; bus.p_data = 32'hA;
    bus.s_valid = 1'b1; bus.s_addr = 5'd3; bus.s_data = 32'hB;
    tick();
    idle();
    chk("same_first_wd3", bus.wd3, 32'hA);
    chk("same_first_we3", bus.we3, 1);
    tick();
    chk("same_second_we3", bus.we3, 1);
    chk("same_second_wd3", bus.wd3, 32'hB);
    tick();
    chk("same_done_we3", bus.we3, 0);
    chk("same_reg3", regs[3], 32'hB);

    // Register 0 writes are discarded
    bus.p_we = 1'b1; bus.p_addr = 5'd0; bus.p_data = 32'h55;
    bus.s_valid = 1'b1; bus.s_addr = 5'd0; bus.s_data = 32'h66; bus.a1 = 5'd0;
    tick();
    idle();
    chk("r0_we3", bus.we3, 0);
    chk("r0_haz1", bus.hazard1, 0);
    chk("r0_s_ready", bus.s_ready, 1);
    tick();
    chk("r0_no_enqueue_we3", bus.we3, 0);

    // Async reset with three entries queued
    bus.p_we = 1'b1; bus.p_addr = 5'd1; bus.p_data = 32'h300;
    for (int k = 0; k < 3; k++) begin
      bus.s_valid = 1'b1; bus.s_addr = 5'(20 + k); bus.s_data = 32'(k + 100);
      tick();
    end
    idle();
    bus.a1 = 5'd20;
    #0;
    chk("rstq_haz1_before", bus.hazard1, 1);
    chk("rstq_we3_before", bus.we3, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstq_we3", bus.we3, 0);
    chk("rstq_s_ready", bus.s_ready, 1);
    chk("rstq_haz1", bus.hazard1, 0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rstq_no_write", bus.we3, 0);
    end
    chk("rstq_reg20", regs[20], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
